// File: rtl/sub.sv
// Single-cycle add/subtract stage with wrap-around and saturated results.
// Define SUB_PIPE2_EN to insert a register between the adder and saturation (two-clock latency).
module sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operator,
  input  logic             data_type,
  input  logic             parser_done,
  output logic [WIDTH-1:0] result,
  output logic             alu_done,
  output logic [WIDTH-1:0] alu_out
);

  localparam int unsigned SW = WIDTH + 1;
  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] b_x_c;
  logic [SW-1:0]    sum_c;

  // Subtract is a + ~b + 1; the carry-out doubles as the unsigned no-borrow flag.
  always_comb begin
    b_x_c = operator ? ~b : b;
    sum_c = SW'({1'b0, a}) + SW'({1'b0, b_x_c}) + SW'(operator);
  end

  logic [SW-1:0] sat_sum_c;
  logic          sat_a_msb_c;
  logic          sat_bx_msb_c;
  logic          sat_op_c;
  logic          sat_dt_c;
  logic          sat_vld_c;

`ifdef SUB_PIPE2_EN
  logic [SW-1:0] sum_q;
  logic          a_msb_q;
  logic          bx_msb_q;
  logic          op_q;
  logic          dt_q;
  logic          vld_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      sum_q    <= '0;
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
      op_q     <= 1'b0;
      dt_q     <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= parser_done;
      if (parser_done) begin
        sum_q    <= sum_c;
        a_msb_q  <= a[WIDTH-1];
        bx_msb_q <= b_x_c[WIDTH-1];
        op_q     <= operator;
        dt_q     <= data_type;
      end
    end
  end

  always_comb begin
    sat_sum_c    = sum_q;
    sat_a_msb_c  = a_msb_q;
    sat_bx_msb_c = bx_msb_q;
    sat_op_c     = op_q;
    sat_dt_c     = dt_q;
    sat_vld_c    = vld_q;
  end
`else
  always_comb begin
    sat_sum_c    = sum_c;
    sat_a_msb_c  = a[WIDTH-1];
    sat_bx_msb_c = b_x_c[WIDTH-1];
    sat_op_c     = operator;
    sat_dt_c     = data_type;
    sat_vld_c    = parser_done;
  end
`endif

  logic [WIDTH-1:0] sat_c;

  // Clamp on unsigned carry/borrow or signed overflow.
  always_comb begin
    sat_c = sat_sum_c[WIDTH-1:0];
    if (!sat_dt_c) begin
      if (!sat_op_c && sat_sum_c[WIDTH]) begin
        sat_c = UMAX;
      end else if (sat_op_c && !sat_sum_c[WIDTH]) begin
        sat_c = '0;
      end
    end else if ((sat_a_msb_c == sat_bx_msb_c) && (sat_sum_c[WIDTH-1] != sat_a_msb_c)) begin
      sat_c = sat_a_msb_c ? SMIN : SMAX;
    end
  end

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             alu_done_q, alu_done_d;

  always_comb begin
    result_d   = result_q;
    alu_out_d  = alu_out_q;
    alu_done_d = sat_vld_c;
    if (sat_vld_c) begin
      result_d  = sat_sum_c[WIDTH-1:0];
      alu_out_d = sat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      result_q   <= '0;
      alu_out_q  <= '0;
      alu_done_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      alu_out_q  <= alu_out_d;
      alu_done_q <= alu_done_d;
    end
  end

  assign result   = result_q;
  assign alu_out  = alu_out_q;
  assign alu_done = alu_done_q;

endmodule

// File: tb/tb_sub.sv
// Directed self-checking bench for sub; expected values are hand-computed.
module tb_sub;

`ifdef SUB_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] a, b;
  logic        operator, data_type, parser_done;
  logic [31:0] result, alu_out;
  logic        alu_done;

  int errors = 0;
  int checks = 0;

  sub dut (
    .clk(clk), .n_rst(n_rst), .a(a), .b(b), .operator(operator),
    .data_type(data_type), .parser_done(parser_done),
    .result(result), .alu_done(alu_done), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b1; parser_done = 1'b0; a = '0; b = '0; operator = 1'b0; data_type = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    checks++;
    if (alu_out !== 32'h0) begin errors++; $display("FAIL reset_alu_out got=%h exp=%h", alu_out, 32'h0); end
    checks++;
    if (alu_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", alu_done); end
    n_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic op, input logic dt,
                         input logic [31:0] exp_res, input logic [31:0] exp_sat);
    a = av; b = bv; operator = op; data_type = dt; parser_done = 1'b1;
    @(negedge clk);
    parser_done = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (result !== exp_res) begin errors++; $display("FAIL %s result got=%h exp=%h", name, result, exp_res); end
    checks++;
    if (alu_out !== exp_sat) begin errors++; $display("FAIL %s alu_out got=%h exp=%h", name, alu_out, exp_sat); end
    checks++;
    if (alu_done !== 1'b1) begin errors++; $display("FAIL %s done got=%b exp=1", name, alu_done); end
    @(negedge clk);
    checks++;
    if (alu_done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got=%b exp=0", name, alu_done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [3] = '{32'd10, 32'd5, 32'd0};
    logic [31:0] bv [3] = '{32'd3, 32'd5, 32'd0};
    logic        ov [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ev [3] = '{32'd7, 32'd10, 32'd0};
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i >= LAT) begin
        checks++;
        if (result !== ev[i-LAT]) begin errors++; $display("FAIL b2b%0d result got=%h exp=%h", i-LAT, result, ev[i-LAT]); end
        checks++;
        if (alu_out !== ev[i-LAT]) begin errors++; $display("FAIL b2b%0d alu_out got=%h exp=%h", i-LAT, alu_out, ev[i-LAT]); end
        checks++;
        if (alu_done !== 1'b1) begin errors++; $display("FAIL b2b%0d done got=%b exp=1", i-LAT, alu_done); end
      end
      if (i < 3) begin
        a = av[i]; b = bv[i]; operator = ov[i]; data_type = 1'b0; parser_done = 1'b1;
      end else begin
        parser_done = 1'b0; a = 32'h12345678;
      end
      @(negedge clk);
    end
    repeat (2) begin
      checks++;
      if (alu_done !== 1'b0) begin errors++; $display("FAIL hold done got=%b exp=0", alu_done); end
      checks++;
      if (result !== 32'h0 || alu_out !== 32'h0) begin
        errors++; $display("FAIL hold outputs got=%h/%h exp=0/0", result, alu_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_priority();
    test_op("pre_rst", 32'd5, 32'd5, 1'b0, 1'b0, 32'd10, 32'd10);
    a = 32'd100; b = 32'd1; operator = 1'b0; data_type = 1'b0;
    parser_done = 1'b1; n_rst = 1'b1;
    @(negedge clk);
    parser_done = 1'b0; n_rst = 1'b0;
    repeat (LAT) begin
      checks++;
      if (alu_done !== 1'b0) begin errors++; $display("FAIL rst_prio done got=%b exp=0", alu_done); end
      checks++;
      if (result !== 32'h0 || alu_out !== 32'h0) begin
        errors++; $display("FAIL rst_prio outputs got=%h/%h exp=0/0", result, alu_out);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_rst = 1'b1; parser_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_op("sub_signed",   32'd123,       32'd456,  1'b1, 1'b1, 32'hFFFFFEB3, 32'hFFFFFEB3);
    test_op("sub_uborrow",  32'd123,       32'd456,  1'b1, 1'b0, 32'hFFFFFEB3, 32'h00000000);
    test_op("sub_unsigned", 32'd456,       32'd123,  1'b1, 1'b0, 32'h0000014D, 32'h0000014D);
    test_op("add_ucarry",   32'hFFFFFFF0,  32'h20,   1'b0, 1'b0, 32'h00000010, 32'hFFFFFFFF);
    test_op("add_unsigned", 32'd1,         32'd2,    1'b0, 1'b0, 32'h00000003, 32'h00000003);
    test_op("add_spos_ovf", 32'h7FFFFFFF,  32'd1,    1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF);
    test_op("sub_sneg_ovf", 32'h80000000,  32'd1,    1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000);
    test_op("add_sneg",     32'hFFFFFFFF,  32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE);
    test_op("sub_eq_u",     32'h00001234,  32'h00001234, 1'b1, 1'b0, 32'h0, 32'h0);
    test_op("sub_eq_s",     32'h80000000,  32'h80000000, 1'b1, 1'b1, 32'h0, 32'h0);
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub.md
Name: sub

Overview:
- Single-cycle integer add/subtract execution stage behind the command parser.
- Captures operands `a`/`b` when `parser_done` is high and computes `a-b` (or `a+b`) in unsigned or signed mode.
- Returns a modulo-2^32 `result`, a saturated `alu_out`, and a one-cycle `alu_done` strobe to the downstream writeback/output logic.

Parameters:
- WIDTH, 32, operand and result width. All ports below are sized by WIDTH; the 32-bit widths shown are the default.

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  reset; synchronous, active-high (1 = reset, sampled on `clk` rising edge)
- a  input  32  minuend / first addend
- b  input  32  subtrahend / second addend
- operator  input  1  1 = subtract (a-b); 0 = add (a+b)
- data_type  input  1  1 = signed two's complement; 0 = unsigned
- parser_done  input  1  operand-valid strobe; sampled each cycle
- result  output  32  registered wrap-around result (mod 2^32)
- alu_done  output  1  one-cycle completion strobe
- alu_out  output  32  registered saturated result

Behaviour:
- Reset (`n_rst`=1 at a clock edge):
  - `result`=0, `alu_out`=0, `alu_done`=0.
  - Reset has priority over `parser_done` in the same cycle; an op launched that cycle is dropped.
- Launch: when `parser_done`=1 at a clock edge and not in reset, compute from the `a`, `b`, `operator`, `data_type` sampled on that edge.
  - `result` and `alu_out` update on that same edge.
  - `alu_done`=1 for exactly that following cycle.
  - Latency: one clock.
- Idle: when `parser_done`=0, `alu_done`=0 and `result`/`alu_out` hold their last values.
- Back-to-back: `parser_done` high on consecutive edges launches an op on every edge; `alu_done` stays high continuously and the outputs update every cycle. No busy/stall path.
- Arithmetic:
  - Compute `s` = `a + (operator ? ~b : b) + operator` in WIDTH+1 bits.
  - `result` = s[WIDTH-1:0] in all modes.
- Saturation (`alu_out`), unsigned mode (`data_type`=0):
  - add with carry-out: 0xFFFFFFFF.
  - subtract with borrow (a<b): 0.
  - otherwise: `result`.
- Saturation (`alu_out`), signed mode (`data_type`=1):
  - overflow = operand signs (after b inversion for subtract) equal and result sign differs.
  - positive overflow: 0x7FFFFFFF.
  - negative overflow: 0x80000000.
  - otherwise: `result`.
- Boundaries:
  - a==b subtract gives 0 in both modes.
  - 0x80000000 - 1 signed gives `result`=0x7FFFFFFF and `alu_out`=0x80000000.
- Reset mid-stream: the op in flight is discarded and outputs clear on the next edge.
- Inputs other than at launch edges are don't-care.

Optional Feature:
- Macro: SUB_PIPE2_EN.
- When defined:
  - An extra register stage sits between the adder and the saturation logic; latency becomes two clocks.
  - `alu_done` is asserted two edges after the launching edge.
  - Back-to-back throughput stays one op per cycle.
  - Reset clears both stages.
- When undefined: one-clock latency as specified above.

Test Plan:
- Reset then sub-signed: hold `n_rst`=1 two cycles, release; `a`=123, `b`=456, `operator`=1, `data_type`=1, `parser_done`=1 one cycle.
  - Expect next cycle: `result`=0xFFFFFEB3 (-333), `alu_out`=0xFFFFFEB3, `alu_done`=1 for exactly one cycle.
- Unsigned borrow: same operands, `data_type`=0.
  - Expect `result`=0xFFFFFEB3, `alu_out`=0x00000000.
- Unsigned add carry: `a`=0xFFFFFFF0, `b`=0x20, `operator`=0, `data_type`=0.
  - Expect `result`=0x00000010, `alu_out`=0xFFFFFFFF.
- Signed overflows:
  - `a`=0x7FFFFFFF + `b`=1 gives `result`=0x80000000, `alu_out`=0x7FFFFFFF.
  - `a`=0x80000000 - `b`=1 gives `result`=0x7FFFFFFF, `alu_out`=0x80000000.
- Back-to-back and hold: three consecutive `parser_done` cycles (10-3, 5+5, 0-0) give per-cycle outputs 7, 10, 0 with `alu_done` high three cycles. Afterwards, with `parser_done`=0, outputs hold 0 and `alu_done`=0.
- Reset priority: assert `n_rst`=1 in the same cycle as `parser_done`=1.
  - Expect `alu_done`=0 and outputs 0 on the next cycle.
